// File: rtl/div_share_pkg.sv
// Shared types for the divider-sharing controller.
// Holds the FSM state encoding, the requester-id width helper and the
// result record returned on the response channel. The result record is
// sized by the package widths; the top-level parameters default to them.
package div_share_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam int unsigned DIV_WIDTH = 8;
    localparam int unsigned DIV_NREQ  = 4;

    // Index width for n requesters; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned DIV_ID_W = id_width(DIV_NREQ);

    typedef struct packed {
        logic [DIV_ID_W-1:0]  id;
        logic [DIV_WIDTH-1:0] quotient;
        logic [DIV_WIDTH-1:0] remainder;
        logic                 err;
    } result_t;

endpackage

// File: rtl/div_share_rr_arbiter.sv
// Round-robin arbiter: searches the request vector starting at the pointer
// and returns the first set requester as a one-hot grant plus its index.
// Ports:
//   i_req   - request vector
//   i_ptr   - index of highest-priority requester this cycle
//   o_grant - one-hot grant (zero when no request)
//   o_idx   - encoded index of the granted requester
//   o_any   - at least one request present
module rr_arbiter
    import div_share_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]           i_req,
    input  logic [id_width(N)-1:0] i_ptr,
    output logic [N-1:0]           o_grant,
    output logic [id_width(N)-1:0] o_idx,
    output logic                   o_any
);

    localparam int unsigned IW = id_width(N);

    logic [IW-1:0] w_j;

    // Rotating priority scan; first hit from the pointer wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_j     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            w_j = IW'((32'(i_ptr) + k) % N);
            if (!o_any && i_req[w_j]) begin
                o_grant[w_j] = 1'b1;
                o_idx        = w_j;
                o_any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_share_ctrl.sv
// Shares one iterative unsigned divider core among NREQ requesters.
// One operation in flight: arbitrate (IDLE), pulse go (ISSUE), wait for
// done (WAIT), present the tagged result until accepted (RESP).
// Optional feature macro: DIV_ZERO_TRAP_EN -- a zero divisor bypasses the
// core and returns quotient all-ones, remainder = dividend, err = 1.
// Ports:
//   clk, reset                 - clock, asynchronous active-high reset
//   req_valid/left/right/ready - per-requester request channel (packed slots)
//   resp_valid/ready/id/quotient/remainder/err - response channel
//   div_go/left/right          - start pulse and operands to the core
//   div_quotient/remainder/done- results and completion from the core
//   ops_done                   - completed-response counter (wraps)
module div_share_ctrl
    import div_share_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH,
    parameter int unsigned NREQ  = DIV_NREQ
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*WIDTH-1:0]    req_left,
    input  logic [NREQ*WIDTH-1:0]    req_right,
    output logic [NREQ-1:0]          req_ready,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [id_width(NREQ)-1:0] resp_id,
    output logic [WIDTH-1:0]         resp_quotient,
    output logic [WIDTH-1:0]         resp_remainder,
    output logic                     resp_err,
    output logic                     div_go,
    output logic [WIDTH-1:0]         div_left,
    output logic [WIDTH-1:0]         div_right,
    input  logic [WIDTH-1:0]         div_quotient,
    input  logic [WIDTH-1:0]         div_remainder,
    input  logic                     div_done,
    output logic [15:0]              ops_done
);

    localparam int unsigned ID_W = id_width(NREQ);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [ID_W-1:0]  r_ptr;
    logic [ID_W-1:0]  r_id;
    logic [WIDTH-1:0] r_left;
    logic [WIDTH-1:0] r_right;
    result_t          r_res;
    logic             r_div_go;
    logic             r_resp_valid;
    logic [15:0]      r_ops_done;

    logic [NREQ-1:0]  w_grant;
    logic [ID_W-1:0]  w_idx;
    logic             w_any;
    logic [WIDTH-1:0] w_win_left;
    logic [WIDTH-1:0] w_win_right;
    logic             w_take;
    logic             w_trap;
    logic             w_capture;
    logic             w_resp_hs;

    rr_arbiter #(.N(NREQ)) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_win_left  = req_left[w_idx*WIDTH +: WIDTH];
    assign w_win_right = req_right[w_idx*WIDTH +: WIDTH];

    // Accept is only offered while idle, to the arbiter winner alone.
    assign req_ready = (r_state == IDLE) ? w_grant : '0;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and transfer strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_trap      = 1'b0;
        w_capture   = 1'b0;
        w_resp_hs   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_take      = 1'b1;
                    w_state_nxt = ISSUE;
`ifdef DIV_ZERO_TRAP_EN
                    if (w_win_right == '0) begin
                        w_trap      = 1'b1;
                        w_state_nxt = RESP;
                    end
`endif
                end
            end
            ISSUE: begin
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (div_done) begin
                    w_capture   = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    w_resp_hs   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Operand latches, result record, pointer and registered strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr        <= '0;
            r_id         <= '0;
            r_left       <= '0;
            r_right      <= '0;
            r_res        <= '0;
            r_div_go     <= 1'b0;
            r_resp_valid <= 1'b0;
            r_ops_done   <= '0;
        end else begin
            if (w_take) begin
                r_id    <= w_idx;
                r_left  <= w_win_left;
                r_right <= w_win_right;
                r_ptr   <= (32'(w_idx) == NREQ - 1) ? '0 : ID_W'(32'(w_idx) + 1);
            end
            if (w_trap) begin
                r_res.id        <= DIV_ID_W'(w_idx);
                r_res.quotient  <= '1;
                r_res.remainder <= DIV_WIDTH'(w_win_left);
                r_res.err       <= 1'b1;
            end
            if (w_capture) begin
                r_res.id        <= DIV_ID_W'(r_id);
                r_res.quotient  <= DIV_WIDTH'(div_quotient);
                r_res.remainder <= DIV_WIDTH'(div_remainder);
                r_res.err       <= 1'b0;
            end
            // Go exists only for the single ISSUE cycle.
            r_div_go     <= (w_state_nxt == ISSUE);
            r_resp_valid <= (w_state_nxt == RESP);
            if (w_resp_hs) begin
                r_ops_done <= r_ops_done + 16'd1;
            end
        end
    end

    assign div_go         = r_div_go;
    assign div_left       = r_left;
    assign div_right      = r_right;
    assign resp_valid     = r_resp_valid;
    assign resp_id        = ID_W'(r_res.id);
    assign resp_quotient  = WIDTH'(r_res.quotient);
    assign resp_remainder = WIDTH'(r_res.remainder);
    assign resp_err       = r_res.err;
    assign ops_done       = r_ops_done;

endmodule

// File: tb/tb_div_share_ctrl.sv
// Directed bench for div_share_ctrl with a behavioural divider core.
module tb_div_share_ctrl;

    localparam int W = 8;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_left = '0;
    logic [N*W-1:0] req_right = '0;
    logic [N-1:0]   req_ready;
    logic           resp_valid;
    logic           resp_ready = 1'b0;
    logic [1:0]     resp_id;
    logic [W-1:0]   resp_quotient;
    logic [W-1:0]   resp_remainder;
    logic           resp_err;
    logic           div_go;
    logic [W-1:0]   div_left;
    logic [W-1:0]   div_right;
    logic [W-1:0]   div_quotient;
    logic [W-1:0]   div_remainder;
    logic           div_done;
    logic [15:0]    ops_done;

    int n_cmp = 0;
    int n_fail = 0;
    int go_cnt = 0;

    always #5 clk = ~clk;

    div_share_ctrl #(.WIDTH(W), .NREQ(N)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_left(req_left), .req_right(req_right),
        .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_quotient(resp_quotient), .resp_remainder(resp_remainder),
        .resp_err(resp_err),
        .div_go(div_go), .div_left(div_left), .div_right(div_right),
        .div_quotient(div_quotient), .div_remainder(div_remainder),
        .div_done(div_done), .ops_done(ops_done)
    );

    // Core stand-in: 4-cycle latency, 1 cycle for a zero dividend.
    logic         cm_busy;
    int           cm_cnt;
    logic [W-1:0] cm_q, cm_r;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cm_busy <= 1'b0; cm_cnt <= 0; div_done <= 1'b0;
            div_quotient <= '0; div_remainder <= '0; cm_q <= '0; cm_r <= '0;
        end else begin
            div_done <= 1'b0;
            if (div_go) begin
                cm_busy <= 1'b1;
                cm_cnt  <= (div_left == 0) ? 1 : 4;
                cm_q    <= (div_right == 0) ? '1 : div_left / div_right;
                cm_r    <= (div_right == 0) ? div_left : div_left % div_right;
            end else if (cm_busy) begin
                if (cm_cnt == 1) begin
                    cm_busy <= 1'b0; div_done <= 1'b1;
                    div_quotient <= cm_q; div_remainder <= cm_r;
                end else cm_cnt <= cm_cnt - 1;
            end
        end
    end

    always @(posedge clk) if (div_go) go_cnt <= go_cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pulse_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    // Offer one request and drop it after the accepting edge.
    task automatic issue(input int id, input int l, input int r);
        bit ok = 0;
        req_left[id*W +: W]  = W'(l);
        req_right[id*W +: W] = W'(r);
        req_valid[id] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (req_ready[id]) begin ok = 1; break; end
            @(negedge clk);
        end
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL issue_accept id%0d: got no ready, want ready", id); end
        @(negedge clk);
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_resp();
        bit ok = 0;
        for (int i = 0; i < 60; i++) begin
            if (resp_valid) begin ok = 1; break; end
            @(negedge clk);
        end
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL resp_timeout: got resp_valid=0, want 1"); end
    endtask

    task automatic handshake();
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; #1;
        n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %0b want 0", resp_valid); end
        n_cmp++; if (div_go !== 1'b0) begin n_fail++; $display("FAIL rst_div_go: got %0b want 0", div_go); end
        n_cmp++; if (ops_done !== 16'd0) begin n_fail++; $display("FAIL rst_ops_done: got %0h want 0", ops_done); end
        n_cmp++; if ({resp_quotient, resp_remainder, div_left, div_right} !== 32'd0) begin n_fail++; $display("FAIL rst_data: got %0h want 0", {resp_quotient, resp_remainder, div_left, div_right}); end
        n_cmp++; if (req_ready !== 4'd0) begin n_fail++; $display("FAIL rst_req_ready: got %0b want 0", req_ready); end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_single();
        int g0 = go_cnt;
        issue(2, 20, 7);
        wait_resp();
        n_cmp++; if (resp_id !== 2'd2) begin n_fail++; $display("FAIL single_id: got %0d want 2", resp_id); end
        n_cmp++; if (resp_quotient !== 8'd2) begin n_fail++; $display("FAIL single_q: got %0d want 2", resp_quotient); end
        n_cmp++; if (resp_remainder !== 8'd6) begin n_fail++; $display("FAIL single_r: got %0d want 6", resp_remainder); end
        n_cmp++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL single_err: got %0b want 0", resp_err); end
        n_cmp++; if (go_cnt - g0 !== 1) begin n_fail++; $display("FAIL single_go_count: got %0d want 1", go_cnt - g0); end
        handshake();
        n_cmp++; if (ops_done !== 16'd1) begin n_fail++; $display("FAIL single_ops_done: got %0d want 1", ops_done); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL single_resp_drop: got %0b want 0", resp_valid); end
    endtask

    task automatic test_round_robin();
        int exp_id[5] = '{0, 1, 2, 3, 0};
        int exp_q[5]  = '{3, 6, 10, 13, 3};
        logic [3:0] one;
        bit ok;
        pulse_reset();
        for (int i = 0; i < N; i++) begin
            req_left[i*W +: W]  = W'(10 * (i + 1));
            req_right[i*W +: W] = 8'd3;
        end
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            ok = 0;
            for (int t = 0; t < 40; t++) begin
                #1;
                if (req_ready != 0) begin ok = 1; break; end
                @(negedge clk);
            end
            one = 4'b0001 << exp_id[k];
            n_cmp++; if (!ok || req_ready !== one) begin n_fail++; $display("FAIL rr_grant_%0d: got %0b want %0b", k, req_ready, one); end
            @(negedge clk);
            if (k == 4) req_valid = '0;
            wait_resp();
            n_cmp++; if (resp_id !== 2'(exp_id[k])) begin n_fail++; $display("FAIL rr_id_%0d: got %0d want %0d", k, resp_id, exp_id[k]); end
            n_cmp++; if (resp_quotient !== 8'(exp_q[k])) begin n_fail++; $display("FAIL rr_q_%0d: got %0d want %0d", k, resp_quotient, exp_q[k]); end
            handshake();
        end
    endtask

    task automatic test_stall();
        int g0;
        issue(1, 100, 9);
        wait_resp();
        g0 = go_cnt;
        req_valid = 4'hF;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            n_cmp++;
            if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_quotient !== 8'd11 ||
                resp_remainder !== 8'd1 || req_ready !== 4'd0 || div_go !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_cycle_%0d: got v=%0b id=%0d q=%0d r=%0d rdy=%0b go=%0b want v=1 id=1 q=11 r=1 rdy=0 go=0",
                         c, resp_valid, resp_id, resp_quotient, resp_remainder, req_ready, div_go);
            end
        end
        n_cmp++; if (go_cnt != g0) begin n_fail++; $display("FAIL stall_go_count: got %0d want %0d", go_cnt, g0); end
        req_valid = '0;
        @(negedge clk);
        handshake();
    endtask

    task automatic test_zero_dividend();
        issue(3, 0, 5);
        wait_resp();
        n_cmp++; if ({resp_quotient, resp_remainder, resp_err} !== 17'd0) begin n_fail++; $display("FAIL zero_dividend: got q=%0d r=%0d err=%0b want 0 0 0", resp_quotient, resp_remainder, resp_err); end
        n_cmp++; if (resp_id !== 2'd3) begin n_fail++; $display("FAIL zero_dividend_id: got %0d want 3", resp_id); end
        handshake();
    endtask

    task automatic test_div_zero();
        int g0 = go_cnt;
        issue(0, 9, 0);
        wait_resp();
`ifdef DIV_ZERO_TRAP_EN
        n_cmp++; if (go_cnt - g0 !== 0) begin n_fail++; $display("FAIL dz_go_count: got %0d want 0", go_cnt - g0); end
        n_cmp++; if (resp_err !== 1'b1) begin n_fail++; $display("FAIL dz_err: got %0b want 1", resp_err); end
`else
        n_cmp++; if (go_cnt - g0 !== 1) begin n_fail++; $display("FAIL dz_go_count: got %0d want 1", go_cnt - g0); end
        n_cmp++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL dz_err: got %0b want 0", resp_err); end
`endif
        n_cmp++; if (resp_quotient !== 8'hFF || resp_remainder !== 8'd9) begin n_fail++; $display("FAIL dz_result: got q=%0h r=%0d want ff 9", resp_quotient, resp_remainder); end
        handshake();
    endtask

    task automatic test_reset_mid();
        issue(0, 200, 3);
        @(negedge clk);
        reset = 1'b1; #1;
        n_cmp++; if ({resp_valid, div_go, req_ready} !== 6'd0) begin n_fail++; $display("FAIL mid_rst_ctrl: got %0b want 0", {resp_valid, div_go, req_ready}); end
        n_cmp++; if ({div_left, div_right, ops_done} !== 32'd0) begin n_fail++; $display("FAIL mid_rst_data: got %0h want 0", {div_left, div_right, ops_done}); end
        @(negedge clk); reset = 1'b0;
        issue(0, 15, 4);
        wait_resp();
        n_cmp++; if (resp_id !== 2'd0 || resp_quotient !== 8'd3 || resp_remainder !== 8'd3) begin n_fail++; $display("FAIL mid_rst_next: got id=%0d q=%0d r=%0d want 0 3 3", resp_id, resp_quotient, resp_remainder); end
        handshake();
        n_cmp++; if (ops_done !== 16'd1) begin n_fail++; $display("FAIL mid_rst_ops: got %0d want 1", ops_done); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_zero_dividend();
        test_div_zero();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
